// File: rtl/rf_alu_pkg.sv
// Shared types for the register-file + ALU execute unit: op codes, immediate
// select encodings, sequencer states and NZVC flag bit positions.
package rf_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBC = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_SEXT5  = 2'b00,
    IMM_SEXT8  = 2'b01,
    IMM_ZEXT8  = 2'b10,
    IMM_ZEXT16 = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/rf_alu_regfile.sv
// NREG x DATA_W general-purpose registers: three asynchronous read ports and
// two synchronous write ports (writeback and external), writeback has priority.
module rf_alu_regfile
  import rf_alu_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned NREG   = 8,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AW-1:0]     i_ra_addr,
  input  logic [AW-1:0]     i_rb_addr,
  input  logic [AW-1:0]     i_rc_addr,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data,
  output logic [DATA_W-1:0] o_rc_data,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_ext_we,
  input  logic [AW-1:0]     i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_data
);

  logic [DATA_W-1:0] r_regs [NREG];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_regs <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (i_wb_we && (i_wb_addr == AW'(i))) begin
          r_regs[i] <= i_wb_data;
        end else if (i_ext_we && (i_ext_addr == AW'(i))) begin
          r_regs[i] <= i_ext_data;
        end
      end
    end
  end

  assign o_ra_data = r_regs[i_ra_addr];
  assign o_rb_data = r_regs[i_rb_addr];
  assign o_rc_data = r_regs[i_rc_addr];

endmodule

// File: rtl/rf_alu_exec_unit.sv
// Register file + ALU execute unit: one op per start handshake, sequenced
// IDLE -> READ -> EXEC -> WB with registered result and NZVC flags.
module rf_alu_exec_unit
  import rf_alu_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned NREG   = 8,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        alu_ctrl,
  input  logic              b_sel,
  input  logic [1:0]        imm_sel,
  input  logic [15:0]       instr,
  input  logic [AW-1:0]     rd_addr,
  input  logic [AW-1:0]     rm_addr,
  input  logic [AW-1:0]     rn_addr,
  input  logic              wb_en,
  input  logic              flags_en,
  input  logic              ext_we,
  input  logic [AW-1:0]     ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_out,
  output logic [3:0]        nzvc,
  output logic [DATA_W-1:0] reada_data
);

  state_e            r_state;
  alu_op_e           r_op;
  logic [DATA_W-1:0] r_a, r_b, r_alu_out;
  logic [AW-1:0]     r_rd;
  logic              r_wb_en, r_flags_en, r_busy, r_done;
  logic [3:0]        r_nzvc;

  logic [DATA_W-1:0] w_rm_data, w_rn_data, w_rd_data, w_imm, w_b_op, w_res;
  logic [DATA_W:0]   w_sum;
  logic              w_cin, w_wb_we, w_unused;
  logic [3:0]        w_flags;

  assign w_wb_we = (r_state == ST_WB) && r_wb_en;

  rf_alu_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ra_addr  (rm_addr),
    .i_rb_addr  (rn_addr),
    .i_rc_addr  (rd_addr),
    .o_ra_data  (w_rm_data),
    .o_rb_data  (w_rn_data),
    .o_rc_data  (w_rd_data),
    .i_wb_we    (w_wb_we),
    .i_wb_addr  (r_rd),
    .i_wb_data  (r_alu_out),
    .i_ext_we   (ext_we),
    .i_ext_addr (ext_waddr),
    .i_ext_data (ext_wdata)
  );

  // Only the low byte of Rd feeds the 16-bit immediate splice.
  assign w_unused = &{1'b0, instr[15:8], w_rd_data[DATA_W-1:8]};

  always_comb begin
    w_imm = '0;
    case (imm_sel_e'(imm_sel))
      IMM_SEXT5:  w_imm = DATA_W'($signed(instr[4:0]));
      IMM_SEXT8:  w_imm = DATA_W'($signed(instr[7:0]));
      IMM_ZEXT8:  w_imm = DATA_W'(instr[7:0]);
      IMM_ZEXT16: w_imm = DATA_W'({instr[7:0], w_rd_data[7:0]});
      default:    w_imm = '0;
    endcase
  end

  // Subtraction is the add form A + ~B + cin, so C=1 means no borrow.
  always_comb begin
    w_b_op = r_b;
    w_cin  = 1'b0;
    case (r_op)
      OP_ADD: w_cin = 1'b0;
      OP_ADC: w_cin = r_nzvc[FLAG_C];
      OP_SUB: begin w_b_op = ~r_b; w_cin = 1'b1; end
      OP_SBC: begin w_b_op = ~r_b; w_cin = r_nzvc[FLAG_C]; end
      default: w_cin = 1'b0;
    endcase
    w_sum           = {1'b0, r_a} + {1'b0, w_b_op} + (DATA_W+1)'(w_cin);
    w_res           = w_sum[DATA_W-1:0];
    w_flags         = '0;
    w_flags[FLAG_N] = w_res[DATA_W-1];
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_V] = (r_a[DATA_W-1] == w_b_op[DATA_W-1]) && (w_res[DATA_W-1] != r_a[DATA_W-1]);
    w_flags[FLAG_C] = w_sum[DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_rd       <= '0;
      r_wb_en    <= 1'b0;
      r_flags_en <= 1'b0;
      r_alu_out  <= '0;
      r_nzvc     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_READ;
            r_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          r_a        <= w_rm_data;
          r_b        <= b_sel ? w_imm : w_rn_data;
          r_op       <= alu_op_e'(alu_ctrl);
          r_rd       <= rd_addr;
          r_wb_en    <= wb_en;
          r_flags_en <= flags_en;
          r_state    <= ST_EXEC;
        end
        ST_EXEC: begin
          r_alu_out <= w_res;
          if (r_flags_en) r_nzvc <= w_flags;
          r_done    <= 1'b1;
          r_state   <= ST_WB;
        end
        ST_WB: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign alu_out    = r_alu_out;
  assign nzvc       = r_nzvc;
  assign reada_data = w_rm_data;

endmodule

// File: tb/tb_rf_alu_exec_unit.sv
// Directed self-checking bench for rf_alu_exec_unit (DATA_W=16, NREG=8).
module tb_rf_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  alu_ctrl = 2'b00;
  logic        b_sel = 1'b0;
  logic [1:0]  imm_sel = 2'b00;
  logic [15:0] instr = 16'h0000;
  logic [2:0]  rd_addr = 3'd0, rm_addr = 3'd0, rn_addr = 3'd0;
  logic        wb_en = 1'b0, flags_en = 1'b0;
  logic        ext_we = 1'b0;
  logic [2:0]  ext_waddr = 3'd0;
  logic [15:0] ext_wdata = 16'h0000;
  logic        busy, done;
  logic [15:0] alu_out, reada_data;
  logic [3:0]  nzvc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_alu_exec_unit #(.DATA_W(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl), .b_sel(b_sel),
    .imm_sel(imm_sel), .instr(instr), .rd_addr(rd_addr), .rm_addr(rm_addr),
    .rn_addr(rn_addr), .wb_en(wb_en), .flags_en(flags_en), .ext_we(ext_we),
    .ext_waddr(ext_waddr), .ext_wdata(ext_wdata), .busy(busy), .done(done),
    .alu_out(alu_out), .nzvc(nzvc), .reada_data(reada_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    @(posedge clk);
    #1 ext_we = 1'b0;
  endtask

  // Issues one op and returns at the falling edge of the WB cycle.
  task automatic run_op(input logic [1:0] ctrl, input logic bs, input logic [1:0] is,
                        input logic [15:0] ins, input logic [2:0] rd, input logic [2:0] rm,
                        input logic [2:0] rn, input logic wb, input logic fe, output int lat);
    @(negedge clk);
    alu_ctrl = ctrl; b_sel = bs; imm_sel = is; instr = ins;
    rd_addr = rd; rm_addr = rm; rn_addr = rn; wb_en = wb; flags_en = fe;
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) begin
      n_fail++;
      $display("FAIL op_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (alu_out !== 16'h0000) begin n_fail++; $display("FAIL reset_alu_out: got %h expected 0000", alu_out); end
    n_checks++; if (nzvc !== 4'b0000) begin n_fail++; $display("FAIL reset_nzvc: got %b expected 0000", nzvc); end
    for (int i = 0; i < 8; i++) begin
      rm_addr = 3'(i);
      #1;
      n_checks++;
      if (reada_data !== 16'h0000) begin n_fail++; $display("FAIL reset_reg R%0d: got %h expected 0000", i, reada_data); end
    end
  endtask

  task automatic test_add();
    int lat;
    for (int i = 0; i < 8; i++) ext_write(3'(i), 16'(i));
    @(negedge clk);
    rm_addr = 3'd5; #1;
    n_checks++; if (reada_data !== 16'h0005) begin n_fail++; $display("FAIL ext_load R5: got %h expected 0005", reada_data); end
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd3, 3'd5, 1'b0, 1'b1, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_in_wb: got %b expected 1", busy); end
    n_checks++; if (alu_out !== 16'h0008) begin n_fail++; $display("FAIL add_result: got %h expected 0008", alu_out); end
    n_checks++; if (nzvc !== 4'b0000) begin n_fail++; $display("FAIL add_nzvc: got %b expected 0000", nzvc); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_sub();
    int lat;
    run_op(2'b10, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd3, 3'd5, 1'b0, 1'b1, lat);
    n_checks++; if (alu_out !== 16'hFFFE) begin n_fail++; $display("FAIL sub_3_5: got %h expected FFFE", alu_out); end
    n_checks++; if (nzvc !== 4'b1000) begin n_fail++; $display("FAIL sub_3_5_nzvc: got %b expected 1000", nzvc); end
    run_op(2'b10, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd5, 3'd3, 1'b0, 1'b1, lat);
    n_checks++; if (alu_out !== 16'h0002) begin n_fail++; $display("FAIL sub_5_3: got %h expected 0002", alu_out); end
    n_checks++; if (nzvc !== 4'b0001) begin n_fail++; $display("FAIL sub_5_3_nzvc: got %b expected 0001", nzvc); end
  endtask

  task automatic test_imm();
    int lat;
    run_op(2'b00, 1'b1, 2'b00, 16'h001F, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, lat);
    n_checks++; if (alu_out !== 16'h0001) begin n_fail++; $display("FAIL imm_sext5: got %h expected 0001", alu_out); end
    run_op(2'b00, 1'b1, 2'b01, 16'h0080, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, lat);
    n_checks++; if (alu_out !== 16'hFF82) begin n_fail++; $display("FAIL imm_sext8: got %h expected FF82", alu_out); end
    run_op(2'b00, 1'b1, 2'b10, 16'h00FF, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, lat);
    n_checks++; if (alu_out !== 16'h0101) begin n_fail++; $display("FAIL imm_zext8: got %h expected 0101", alu_out); end
    ext_write(3'd4, 16'hABAB);
    run_op(2'b00, 1'b1, 2'b11, 16'h00FF, 3'd4, 3'd2, 3'd0, 1'b0, 1'b0, lat);
    n_checks++; if (alu_out !== 16'hFFAD) begin n_fail++; $display("FAIL imm_zext16: got %h expected FFAD", alu_out); end
    n_checks++; if (nzvc !== 4'b0001) begin n_fail++; $display("FAIL imm_nzvc_hold: got %b expected 0001", nzvc); end
  endtask

  task automatic test_carry();
    int lat;
    ext_write(3'd7, 16'hFFFF);
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd3, 3'd7, 1'b0, 1'b1, lat);
    n_checks++; if (alu_out !== 16'h0002) begin n_fail++; $display("FAIL carry_add: got %h expected 0002", alu_out); end
    n_checks++; if (nzvc !== 4'b0001) begin n_fail++; $display("FAIL carry_add_nzvc: got %b expected 0001", nzvc); end
    ext_write(3'd7, 16'h0007);
    run_op(2'b01, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd6, 3'd7, 1'b0, 1'b1, lat);
    n_checks++; if (alu_out !== 16'h000E) begin n_fail++; $display("FAIL adc: got %h expected 000E", alu_out); end
    n_checks++; if (nzvc !== 4'b0000) begin n_fail++; $display("FAIL adc_nzvc: got %b expected 0000", nzvc); end
    run_op(2'b11, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd6, 3'd7, 1'b0, 1'b1, lat);
    n_checks++; if (alu_out !== 16'hFFFE) begin n_fail++; $display("FAIL sbc: got %h expected FFFE", alu_out); end
    n_checks++; if (nzvc !== 4'b1000) begin n_fail++; $display("FAIL sbc_nzvc: got %b expected 1000", nzvc); end
  endtask

  task automatic test_overflow();
    int lat;
    ext_write(3'd1, 16'h7FFF);
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd1, 3'd1, 1'b0, 1'b1, lat);
    n_checks++; if (alu_out !== 16'hFFFE) begin n_fail++; $display("FAIL ovf_result: got %h expected FFFE", alu_out); end
    n_checks++; if (nzvc !== 4'b1010) begin n_fail++; $display("FAIL ovf_nzvc: got %b expected 1010", nzvc); end
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd3, 3'd5, 1'b0, 1'b1, lat);
    n_checks++; if (nzvc !== 4'b0000) begin n_fail++; $display("FAIL ovf_clear_nzvc: got %b expected 0000", nzvc); end
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd1, 3'd1, 1'b0, 1'b0, lat);
    n_checks++; if (alu_out !== 16'hFFFE) begin n_fail++; $display("FAIL ovf_noflag_result: got %h expected FFFE", alu_out); end
    n_checks++; if (nzvc !== 4'b0000) begin n_fail++; $display("FAIL ovf_noflag_nzvc: got %b expected 0000", nzvc); end
  endtask

  task automatic test_back_to_back();
    int  lat;
    time t1, t2;
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd2, 3'd3, 1'b0, 1'b0, lat);
    t1 = $time;
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd4, 3'd3, 1'b0, 1'b0, lat);
    t2 = $time;
    n_checks++; if ((t2 - t1) !== 40) begin n_fail++; $display("FAIL b2b_spacing: got %0t expected 40", t2 - t1); end
    n_checks++; if (alu_out !== 16'hABAE) begin n_fail++; $display("FAIL b2b_result: got %h expected ABAE", alu_out); end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    @(negedge clk);
    alu_ctrl = 2'b00; b_sel = 1'b0; rm_addr = 3'd3; rn_addr = 3'd5;
    wb_en = 1'b0; flags_en = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (k == 2) start = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_ignore_done_count: got %0d expected 1", ndone); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_not_queued: got %b expected 0", busy); end
    n_checks++; if (alu_out !== 16'h0008) begin n_fail++; $display("FAIL busy_ignore_result: got %h expected 0008", alu_out); end
  endtask

  task automatic test_wb_priority();
    int lat;
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd3, 3'd5, 1'b1, 1'b0, lat);
    ext_we = 1'b1; ext_waddr = 3'd0; ext_wdata = 16'h1234;
    @(posedge clk);
    #1 ext_we = 1'b0;
    rm_addr = 3'd0; #1;
    n_checks++; if (reada_data !== 16'h0008) begin n_fail++; $display("FAIL wb_wins: got %h expected 0008", reada_data); end
    run_op(2'b00, 1'b0, 2'b00, 16'h0000, 3'd0, 3'd3, 3'd3, 1'b1, 1'b0, lat);
    ext_we = 1'b1; ext_waddr = 3'd2; ext_wdata = 16'h5555;
    @(posedge clk);
    #1 ext_we = 1'b0;
    rm_addr = 3'd0; #1;
    n_checks++; if (reada_data !== 16'h0006) begin n_fail++; $display("FAIL dual_write_wb: got %h expected 0006", reada_data); end
    rm_addr = 3'd2; #1;
    n_checks++; if (reada_data !== 16'h5555) begin n_fail++; $display("FAIL dual_write_ext: got %h expected 5555", reada_data); end
  endtask

  task automatic test_reset_mid_op();
    int ndone = 0;
    @(negedge clk);
    alu_ctrl = 2'b00; b_sel = 1'b0; rm_addr = 3'd3; rn_addr = 3'd5;
    rd_addr = 3'd1; wb_en = 1'b1; flags_en = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if (alu_out !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_alu_out: got %h expected 0000", alu_out); end
    n_checks++; if (nzvc !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_nzvc: got %b expected 0000", nzvc); end
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d expected 0", ndone); end
    rm_addr = 3'd1; #1;
    n_checks++; if (reada_data !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_rd: got %h expected 0000", reada_data); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_imm();
    test_carry();
    test_overflow();
    test_back_to_back();
    test_busy_ignore();
    test_wb_priority();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
